// File: rtl/gbc_capture_pkg.sv
// Shared types and constants for the GBC LCD capture block.
package gbc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } cap_state_e;

    localparam int unsigned GBC_H_PIXELS = 160;
    localparam int unsigned GBC_V_PIXELS = 144;

    localparam int unsigned CM_RGB332 = 0;
    localparam int unsigned CM_GREY2  = 1;

    // Raw GBC pixel bus; DCLK travels with the data so they stay aligned through sync.
    typedef struct packed {
        logic       dclk;
        logic       cls;
        logic       sps;
        logic [2:0] data;
    } gbc_bus_t;

    localparam int unsigned BUS_W = $bits(gbc_bus_t);

    // Expand the 3 captured pixel bits into an 8-bit VRAM colour word.
    function automatic logic [7:0] expand_colour(input logic [2:0] pix, input int unsigned mode);
        if (mode == CM_GREY2) begin
            return {4{pix[1], pix[0]}};
        end
        return {{3{pix[0]}}, {3{pix[1]}}, {2{pix[2]}}};
    endfunction

endpackage

// File: rtl/gbc_capture_sync_sync_edge.sv
// Multi-stage synchroniser for a bus with per-bit rise/fall detection on the synced value.
module gbc_sync_edge #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise_c,
    output logic [WIDTH-1:0] fall_c
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= async_in;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign sync   = stage_q[STAGES-1];
    assign rise_c = sync & ~prev_q;
    assign fall_c = ~sync & prev_q;

endmodule

// File: rtl/gbc_capture_sync.sv
// GBC LCD capture: synchronises the pixel bus, tracks frame position and issues VRAM writes.
module gbc_capture_sync
    import gbc_capture_pkg::*;
#(
    parameter int unsigned H_PIXELS    = GBC_H_PIXELS,
    parameter int unsigned V_PIXELS    = GBC_V_PIXELS,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DOUBLE_BUF  = 1,
    parameter int unsigned COLOR_MODE  = CM_RGB332,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_gbcDCLK,
    input  logic              i_gbcCLS,
    input  logic              i_gbcSPS,
    input  logic [2:0]        i_gbcPixelData,
    output logic              o_vramWe,
    output logic [ADDR_W-1:0] o_vramWriteAddr,
    output logic [7:0]        o_vramDataOut,
    output logic              o_frameDone,
    output logic              o_frontBank,
    output logic              o_frameErr,
    output logic [7:0]        o_frameCount
);

    localparam int unsigned H_W        = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned V_W        = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int unsigned FRAME_SIZE = H_PIXELS * V_PIXELS;

    localparam logic [H_W-1:0]    H_LAST      = H_W'(H_PIXELS - 1);
    localparam logic [V_W-1:0]    V_LAST      = V_W'(V_PIXELS - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(FRAME_SIZE);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_PIXELS);
    localparam logic              WBANK_RST   = (DOUBLE_BUF != 0);

    gbc_bus_t bus_raw;
    gbc_bus_t bus_sync;
    gbc_bus_t bus_rise;
    gbc_bus_t bus_fall;

    assign bus_raw = {i_gbcDCLK, i_gbcCLS, i_gbcSPS, i_gbcPixelData};

    gbc_sync_edge #(
        .WIDTH  (BUS_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (i_clk),
        .rst      (i_rst),
        .async_in (bus_raw),
        .sync     (bus_sync),
        .rise_c   (bus_rise),
        .fall_c   (bus_fall)
    );

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_rise, bus_fall.cls, bus_fall.data, bus_sync.dclk, bus_sync.sps};

    logic dclk_fall_c;
    logic sps_fall_c;
    logic pixel_c;

    assign dclk_fall_c = bus_fall.dclk;
    assign sps_fall_c  = bus_fall.sps;
    assign pixel_c     = dclk_fall_c & bus_sync.cls;

    cap_state_e        state_q, state_n;
    logic [H_W-1:0]    h_q, h_n, wr_h;
    logic [V_W-1:0]    v_q, v_n, wr_v;
    logic              wbank_q, wbank_n;
    logic              front_q, front_n;
    logic [7:0]        count_q, count_n;
    logic              err_q, err_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        data_q, data_n;
    logic              done_q, done_n;
    logic              write_c;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Position, bank, status and VRAM write registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q     <= '0;
            v_q     <= '0;
            wbank_q <= WBANK_RST;
            front_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            h_q     <= h_n;
            v_q     <= v_n;
            wbank_q <= wbank_n;
            front_q <= front_n;
            count_q <= count_n;
            err_q   <= err_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            done_q  <= done_n;
        end
    end

    // Next-state and write generation; a frame sync always rewinds the position before the pixel lands.
    always_comb begin
        state_n = state_q;
        h_n     = h_q;
        v_n     = v_q;
        wbank_n = wbank_q;
        front_n = front_q;
        count_n = count_q;
        err_n   = err_q;
        we_n    = 1'b0;
        addr_n  = addr_q;
        data_n  = data_q;
        done_n  = 1'b0;
        wr_h    = h_q;
        wr_v    = v_q;
        write_c = 1'b0;

        if (!i_enable) begin
            state_n = IDLE;
            err_n   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_n = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (sps_fall_c) begin
                        state_n = CAPTURE;
                        wr_h    = '0;
                        wr_v    = '0;
                        h_n     = '0;
                        v_n     = '0;
                        write_c = pixel_c;
                    end
                end
                CAPTURE: begin
                    if (sps_fall_c) begin
                        err_n = 1'b1;
                        wr_h  = '0;
                        wr_v  = '0;
                        h_n   = '0;
                        v_n   = '0;
                    end
                    write_c = pixel_c;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (write_c) begin
            we_n   = 1'b1;
            addr_n = (wbank_q ? BANK1_BASE : '0) + (ADDR_W'(wr_v) * LINE_STRIDE) + ADDR_W'(wr_h);
            data_n = expand_colour(bus_sync.data, COLOR_MODE);
            if (wr_h == H_LAST) begin
                h_n = '0;
                if (wr_v == V_LAST) begin
                    v_n     = '0;
                    done_n  = 1'b1;
                    count_n = count_q + 8'd1;
                    front_n = wbank_q;
                    state_n = WAIT_FRAME;
                    if (DOUBLE_BUF != 0) begin
                        wbank_n = ~wbank_q;
                    end
                end else begin
                    v_n = wr_v + V_W'(1);
                end
            end else begin
                h_n = wr_h + H_W'(1);
            end
        end
    end

    assign o_vramWe        = we_q;
    assign o_vramWriteAddr = addr_q;
    assign o_vramDataOut   = data_q;
    assign o_frameDone     = done_q;
    assign o_frontBank     = front_q;
    assign o_frameErr      = err_q;
    assign o_frameCount    = count_q;

endmodule

// File: tb/tb_gbc_capture_sync.sv
// Randomised bench for gbc_capture_sync: two configurations driven in parallel against a frame-level model.
module tb_gbc_capture_sync;

    localparam int H  = 10;
    localparam int V  = 6;
    localparam int HV = H * V;
    localparam int S  = 2;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst, en, dclk, cls, sps;
    logic [2:0] data;

    logic          we0, we1, done0, done1, front0, front1, err0, err1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    dat0, dat1, cnt0, cnt1;

    always #5 clk = ~clk;

    gbc_capture_sync #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .DOUBLE_BUF(1),
                       .COLOR_MODE(0), .SYNC_STAGES(S)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_gbcDCLK(dclk), .i_gbcCLS(cls),
        .i_gbcSPS(sps), .i_gbcPixelData(data), .o_vramWe(we0), .o_vramWriteAddr(addr0),
        .o_vramDataOut(dat0), .o_frameDone(done0), .o_frontBank(front0),
        .o_frameErr(err0), .o_frameCount(cnt0));

    gbc_capture_sync #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .DOUBLE_BUF(0),
                       .COLOR_MODE(1), .SYNC_STAGES(S)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_gbcDCLK(dclk), .i_gbcCLS(cls),
        .i_gbcSPS(sps), .i_gbcPixelData(data), .o_vramWe(we1), .o_vramWriteAddr(addr1),
        .o_vramDataOut(dat1), .o_frameDone(done1), .o_frontBank(front1),
        .o_frameErr(err1), .o_frameCount(cnt1));

    int checks = 0;
    int passes = 0;
    bit chk_on = 1'b0;

    // ---------------- frame-level reference model ----------------
    localparam int CFG_DB [2] = '{1, 0};
    localparam int CFG_CM [2] = '{0, 1};

    logic [5:0] hist [0:S];
    int   m_mode  [2];   // 0 idle, 1 waiting for sync, 2 capturing
    int   m_pos   [2];   // linear pixel index within the frame
    int   m_wbank [2];
    int   m_front [2];
    int   m_count [2];
    int   m_err   [2];
    int   m_we    [2];
    int   m_addr  [2];
    int   m_data  [2];
    int   m_done  [2];

    function automatic int colour(input int mode, input logic [2:0] p);
        if (mode == 1) return int'({p[1], p[0]}) * 'h55;
        return (p[0] ? 'hE0 : 0) + (p[1] ? 'h1C : 0) + (p[2] ? 'h03 : 0);
    endfunction

    always @(posedge clk) begin
        logic [5:0] now_s, old_s;
        bit dfall, sfall, pix;
        now_s = hist[S-1];
        old_s = hist[S];
        dfall = old_s[5] && !now_s[5];
        sfall = old_s[3] && !now_s[3];
        pix   = dfall && now_s[4];
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_pos[i] = 0; m_wbank[i] = CFG_DB[i]; m_front[i] = 0;
                m_count[i] = 0; m_err[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_data[i] = 0;
                m_done[i] = 0;
            end else begin
                bit wr;
                wr = 1'b0;
                m_we[i] = 0;
                m_done[i] = 0;
                if (!en) begin
                    m_mode[i] = 0;
                    m_err[i] = 0;
                end else if (m_mode[i] == 0) begin
                    m_mode[i] = 1;
                end else begin
                    if (sfall) begin
                        if (m_mode[i] == 2) m_err[i] = 1;
                        m_mode[i] = 2;
                        m_pos[i] = 0;
                    end
                    wr = (m_mode[i] == 2) && pix;
                end
                if (wr) begin
                    m_we[i] = 1;
                    m_addr[i] = m_wbank[i] * HV + m_pos[i];
                    m_data[i] = colour(CFG_CM[i], now_s[2:0]);
                    if (m_pos[i] == HV - 1) begin
                        m_done[i] = 1;
                        m_count[i] = (m_count[i] + 1) % 256;
                        m_front[i] = m_wbank[i];
                        if (CFG_DB[i] != 0) m_wbank[i] = 1 - m_wbank[i];
                        m_mode[i] = 1;
                        m_pos[i] = 0;
                    end else begin
                        m_pos[i] = m_pos[i] + 1;
                    end
                end
            end
        end
        for (int k = S; k > 0; k--) hist[k] = rst ? 6'd0 : hist[k-1];
        hist[0] = rst ? 6'd0 : {dclk, cls, sps, data};
    end

    // ---------------- per-cycle compare against the model ----------------
    logic [27:0] act_vec [2];
    assign act_vec[0] = {we0, addr0, dat0, done0, front0, err0, cnt0};
    assign act_vec[1] = {we1, addr1, dat1, done1, front1, err1, cnt1};

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                logic [27:0] exp_vec;
                exp_vec = {m_we[i][0], AW'(m_addr[i]), 8'(m_data[i]), m_done[i][0],
                           m_front[i][0], m_err[i][0], 8'(m_count[i])};
                checks++;
                if (act_vec[i] === exp_vec) passes++;
                else $display("FAIL model_cycle dut%0d t=%0t: got we=%b addr=%0d data=%h done=%b front=%b err=%b cnt=%0d, required we=%b addr=%0d data=%h done=%b front=%b err=%b cnt=%0d",
                              i, $time, act_vec[i][27], act_vec[i][26:19], act_vec[i][18:11],
                              act_vec[i][10], act_vec[i][9], act_vec[i][8], act_vec[i][7:0],
                              exp_vec[27], exp_vec[26:19], exp_vec[18:11], exp_vec[10],
                              exp_vec[9], exp_vec[8], exp_vec[7:0]);
            end
        end
    end

    // ---------------- write log for literal checks ----------------
    int wq0[$];
    int wq1[$];
    int last_data [2];
    int done_cnt  [2];
    int done_bad  [2];

    always @(negedge clk) begin
        if (we0) begin wq0.push_back(int'(addr0)); last_data[0] = int'(dat0); end
        if (we1) begin wq1.push_back(int'(addr1)); last_data[1] = int'(dat1); end
        if (done0) begin done_cnt[0]++; if (!we0) done_bad[0]++; end
        if (done1) begin done_cnt[1]++; if (!we1) done_bad[1]++; end
    end

    task automatic clear_log();
        wq0.delete();
        wq1.delete();
        for (int i = 0; i < 2; i++) begin done_cnt[i] = 0; done_bad[i] = 0; end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // ---------------- GBC bus drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send_pixel(input logic c, input logic [2:0] d);
        dclk = 1'b1; cls = c; data = d;
        tick($urandom_range(3, 2));
        dclk = 1'b0;
        tick($urandom_range(3, 2));
    endtask

    task automatic sps_pulse();
        sps = 1'b0;
        tick(3);
        sps = 1'b1;
        tick(2);
    endtask

    task automatic drain();
        tick(5);
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    initial begin
        for (int k = 0; k <= S; k++) hist[k] = 6'd0;
        rst = 1'b1; en = 1'b0; dclk = 1'b0; cls = 1'b0; sps = 1'b1; data = 3'd0;
        tick(4);
        chk_on = 1'b1;
        check("reset_we", int'(we0), 0);
        check("reset_addr", int'(addr0), 0);
        check("reset_cnt_front", int'({cnt1, front0, err0}), 0);
        rst = 1'b0;
        tick(1);

        // Bus activity without enable, then enabled but before sync.
        clear_log();
        repeat (4) send_pixel(1'b1, 3'($urandom));
        en = 1'b1;
        tick(2);
        repeat (3) send_pixel(1'b1, 3'($urandom));
        drain();
        check("no_write_before_sync", wq0.size() + wq1.size(), 0);

        // Frame 1, constant colour.
        sps_pulse();
        clear_log();
        repeat (HV) send_pixel(1'b1, 3'b101);
        drain();
        check("f1_strobes", wq0.size(), HV);
        check("f1_first_addr", qget(wq0, 0), HV);
        check("f1_last_addr", qget(wq0, HV - 1), 2 * HV - 1);
        check("f1_rgb_data", last_data[0], 'hE3);
        check("f1_grey_data", last_data[1], 'h55);
        check("f1_done_once", done_cnt[0] * 10 + done_bad[0], 10);
        check("f1_front", int'(front0), 1);
        check("f1_count", int'(cnt0), 1);
        check("f1_single_bank_last", qget(wq1, HV - 1), HV - 1);

        // Frame 2 with interleaved CLS-low clocks.
        sps_pulse();
        clear_log();
        for (int p = 0; p < HV; p++) begin
            if ($urandom_range(3, 0) == 0) send_pixel(1'b0, 3'($urandom));
            send_pixel(1'b1, 3'b110);
        end
        drain();
        check("f2_strobes", wq0.size(), HV);
        check("f2_first_addr", qget(wq0, 0), 0);
        check("f2_last_addr", qget(wq0, HV - 1), HV - 1);
        check("f2_front", int'(front0), 0);
        check("f2_count", int'(cnt0), 2);
        check("f2_grey_aa", last_data[1], 'hAA);
        check("f2_rgb_1f", last_data[0], 'h1F);

        // Frame 3: CLS-low gap must not advance the position; line wrap lands at base + H.
        sps_pulse();
        clear_log();
        repeat (5) send_pixel(1'b1, 3'($urandom));
        repeat (10) send_pixel(1'b0, 3'($urandom));
        repeat (10) send_pixel(1'b1, 3'($urandom));
        drain();
        check("cls_gap_strobes", wq0.size(), 15);
        check("cls_gap_addr", qget(wq0, 5), HV + 5);
        check("line_wrap_addr", qget(wq0, H), HV + H);
        check("line_wrap_single", qget(wq1, H), H);

        // Early sync mid-frame.
        sps_pulse();
        clear_log();
        send_pixel(1'b1, 3'($urandom));
        drain();
        check("early_sync_err", int'(err0), 1);
        check("early_sync_rewind", qget(wq0, 0), HV);
        check("early_sync_no_done", done_cnt[0], 0);
        check("early_sync_front", int'(front0), 0);
        repeat (HV - 1) send_pixel(1'b1, 3'($urandom));
        drain();
        check("after_err_done", done_cnt[0], 1);
        check("after_err_front", int'(front0), 1);
        check("err_sticky", int'(err0), 1);

        // Enable dropped mid-frame, then re-enabled.
        sps_pulse();
        repeat (20) send_pixel(1'b1, 3'($urandom));
        en = 1'b0;
        tick(3);
        clear_log();
        check("disable_err_clear", int'(err0), 0);
        repeat (6) send_pixel(1'b1, 3'($urandom));
        en = 1'b1;
        tick(2);
        repeat (5) send_pixel(1'b1, 3'($urandom));
        drain();
        check("disable_no_strobes", wq0.size(), 0);
        sps_pulse();
        clear_log();
        repeat (HV) send_pixel(1'b1, 3'($urandom));
        drain();
        check("reenable_first_addr", qget(wq0, 0), 0);
        check("reenable_count", int'(cnt0), 4);

        // Randomised traffic checked purely by the model.
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(99, 0);
            if (r < 5) sps_pulse();
            else if (r < 7) begin en = ~en; tick($urandom_range(3, 1)); end
            else send_pixel(1'($urandom_range(9, 0) != 0), 3'($urandom));
        end
        en = 1'b1;
        tick(2);

        // Reset in the middle of a line.
        sps_pulse();
        repeat (5) send_pixel(1'b1, 3'($urandom));
        dclk = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        check("midrst_outputs", int'({we0, addr0, dat0, done0, front0, err0, cnt0}), 0);
        check("midrst_outputs1", int'({we1, addr1, dat1, done1, front1, err1, cnt1}), 0);
        rst = 1'b0;
        tick(1);
        clear_log();
        repeat (5) send_pixel(1'b1, 3'($urandom));
        drain();
        check("post_rst_no_write", wq0.size(), 0);
        sps_pulse();
        clear_log();
        send_pixel(1'b1, 3'($urandom));
        drain();
        check("post_rst_bank_base", qget(wq0, 0), HV);

        chk_on = 1'b0;
        tick(1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
